// File: rtl/sar_search.sv
// Successive-approximation controller: binary-searches the target held on the
// opposite operand of a G/L/E comparator, MSB first, then verifies the result.
module sar_search #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, TEST, VERIFY} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] trial_n, result_n;
  logic             acc, acc_n;
  logic             done_n, found_n, err_n;
  logic             keep, bad;

  // A bit survives unless the comparator says the target is below the trial;
  // bad flags any sample that is not exactly one-hot.
  assign keep = cmp_g | cmp_e;
  assign bad  = ~((cmp_g ^ cmp_l ^ cmp_e) & ~(cmp_g & cmp_l & cmp_e));
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    trial_n  = trial;
    acc_n    = acc;
    result_n = result;
    found_n  = found;
    err_n    = err;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        trial_n = '0;
        if (start) begin
          state_n          = TEST;
          idx_n            = IDX_W'(WIDTH - 1);
          trial_n[WIDTH-1] = 1'b1;
          acc_n            = 1'b0;
        end
      end
      TEST: begin
        acc_n        = acc | bad;
        trial_n[idx] = keep;
        if (idx != '0) begin
          trial_n[idx - 1'b1] = 1'b1;
          idx_n               = idx - 1'b1;
        end else begin
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        result_n = trial;
        found_n  = cmp_e;
        err_n    = acc | bad;
        done_n   = 1'b1;
        trial_n  = '0;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
        trial_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      trial  <= '0;
      acc    <= 1'b0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      trial  <= trial_n;
      acc    <= acc_n;
      result <= result_n;
      found  <= found_n;
      err    <= err_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural comparator plus a reference
// binary search feed expected trials/results to a negedge monitor.
module tb_sar_search;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         force_fault = 1'b0;
  logic [W-1:0] target = '0;
  logic         cmp_g, cmp_l, cmp_e;
  logic [W-1:0] trial, result;
  logic         busy, done, found, err;

  int n_vec  = 0;
  int n_bad  = 0;
  int ncount = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         fnd;
    logic         er;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] trial_q[$];
  int           due_q[$];

  always #5 clk = ~clk;

  // A forced fault presents g=l=1, e=0 regardless of the operands.
  assign cmp_g = force_fault | (target > trial);
  assign cmp_l = force_fault | (target < trial);
  assign cmp_e = ~force_fault & (target == trial);

  sar_search #(.WIDTH(W), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .found(found), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    n_vec++;
    n_bad++;
    $display("[TB] FAIL %s: event not as required", name);
  endtask

  // Reference: try each bit from the top, keep it unless the target is below.
  task automatic modelSearch(input logic [W-1:0] t1, input logic [W-1:0] t2, input int fault);
    logic [W-1:0] acc;
    logic [W-1:0] t;
    logic [W-1:0] one;
    int g, l, e;
    exp_t x;
    bit er;
    acc = '0;
    one = 1;
    er  = 0;
    for (int j = 0; j < W; j++) begin
      t = acc | (one << (W - 1 - j));
      trial_q.push_back(t);
      if (j == fault) begin
        g = 1; l = 1; e = 0;
      end else begin
        g = (t1 > t) ? 1 : 0;
        l = (t1 < t) ? 1 : 0;
        e = (t1 == t) ? 1 : 0;
      end
      if (g + l + e != 1) er = 1;
      if (g == 1 || e == 1) acc = t;
    end
    trial_q.push_back(acc);
    x.res = acc;
    x.fnd = (acc == t2);
    x.er  = er;
    exp_q.push_back(x);
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 in the done cycle.
  task automatic applyStimulus(input logic [W-1:0] t1, input logic [W-1:0] t2,
                               input int fault, input bit hold, input bit junk);
    target      = t1;
    start       = 1'b1;
    force_fault = 1'b0;
    modelSearch(t1, t2, fault);
    @(posedge clk);
    for (int j = 0; j < W; j++) begin
      #1;
      start       = hold ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
      force_fault = (j == fault);
      @(posedge clk);
    end
    #1;
    force_fault = 1'b0;
    target      = t2;
    start       = hold ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
    @(posedge clk);
    #1;
    start = hold;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_trial", 32'(trial), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_found", 32'(found), 0);
    checkOutput("rst_err", 32'(err), 0);
    exp_q.delete();
    trial_q.delete();
    due_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: trials while busy, result/flags and latency at each done pulse.
  always @(negedge clk) begin
    ncount++;
    if (!rst) begin
      if (busy) begin
        if (trial_q.size() == 0) failNow("trial_extra");
        else checkOutput("trial", 32'(trial), 32'(trial_q.pop_front()));
      end
      if (start && !busy) due_q.push_back(ncount + 7);
      if (done) begin
        if (exp_q.size() == 0) begin
          failNow("spurious_done");
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          checkOutput("result", 32'(result), 32'(x.res));
          checkOutput("found", 32'(found), 32'(x.fnd));
          checkOutput("err", 32'(err), 32'(x.er));
        end
        if (due_q.size() == 0) failNow("done_unexpected_time");
        else checkOutput("done_latency", ncount, due_q.pop_front());
      end else if (due_q.size() > 0 && due_q[0] < ncount) begin
        failNow("done_missing");
        void'(due_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    int fault;
    bit hold;
    #1;
    applyReset();

    applyStimulus(19, 19, -1, 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, -1, 0, 0);
    applyStimulus(31, 31, -1, 0, 1);
    idleCycles(1);
    applyStimulus(7, 7, -1, 1, 1);
    applyStimulus(25, 25, -1, 0, 1);
    idleCycles(1);
    applyStimulus(10, 10, 2, 0, 0);
    idleCycles(1);
    applyStimulus(12, 13, -1, 0, 0);
    idleCycles(2);

    // Abort a search after two bit decisions.
    target = 19;
    start  = 1'b1;
    modelSearch(19, 19, -1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    applyReset();
    idleCycles(3);
    applyStimulus(19, 19, -1, 0, 0);
    idleCycles(1);

    for (int i = 0; i < 40; i++) begin
      t     = int'($urandom_range(0, 31));
      fault = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      hold  = (i < 39) && ($urandom_range(0, 2) == 0);
      applyStimulus(W'(t), W'(t), fault, hold, 1'($urandom_range(0, 1)));
      if (!hold) idleCycles(int'($urandom_range(0, 2)));
    end

    idleCycles(10);
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("trial_q_drained", trial_q.size(), 0);
    checkOutput("due_q_drained", due_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
